pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 16, meaning pixel width in bits; a multiple of 8.
REQ-002 SHALL have parameter LANES, default 8, meaning pixels per chunk; a power of 2, 1..32.
REQ-003 SHALL have parameter ADDR_W, default 20, meaning pixel address width; derived CHUNK_W = ADDR_W - log2(LANES), BYTES = PIX_W/8.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_in  in  1  rising-edge clock.
REQ-006 rst_n_in  in  1  asynchronous active-low reset.
REQ-007 valid_in  in  1  input pixel valid.
REQ-008 addr_in  in  ADDR_W  pixel address; the low log2(LANES) bits are the lane, the upper bits are the chunk.
REQ-009 data_in  in  PIX_W  pixel data.
REQ-010 strobe_in  in  BYTES  per-byte write enables for the pixel.
REQ-011 flush_in  in  1  single-cycle request to emit a partial chunk.
REQ-012 ready_out  out  1  input accept.
REQ-013 valid_out / ready_in  out / in  1 / 1  output handshake.
REQ-014 addr_out  out  CHUNK_W  chunk address.
REQ-015 data_out  out  LANES*PIX_W  lane i occupies bits [i*PIX_W +: PIX_W].
REQ-016 strobe_out  out  LANES*BYTES  byte enables, lane-aligned.
REQ-017 idle_out  out  1  high when the accumulator is empty, no flush is pending and valid_out is 0.
REQ-018 chunks_out / partials_out  out  16 / 16  wrapping counts of emitted chunks and of emitted chunks with mask not all ones.

Function
REQ-019 A pixel SHALL be accepted on a rising edge with valid_in && ready_out.
REQ-020 ready_out SHALL equal !acc_occ || out_free, where out_free = !valid_out || ready_in; it SHALL NOT depend on valid_in, addr_in or flush_in.
REQ-021 The accumulator SHALL hold cur_chunk, LANES data words, a LANES-bit lane mask and acc_occ.
REQ-022 An emit SHALL occur in a cycle with acc_occ && out_free && any of the following: mask all ones; flush pending; an accepted pixel whose chunk differs from cur_chunk.
REQ-023 On emit, the accumulator SHALL be copied to the output register, with valid_out=1 at the next edge.
REQ-024 On emit, strobe_out SHALL be the lane mask AND-ed with the stored byte strobes, and unwritten lanes SHALL output 0 data.
REQ-025 An accepted pixel SHALL start a new accumulator (mask = its lane only, cur_chunk = its chunk) if acc_occ is 0 or an emit occurs in that cycle.
REQ-026 Otherwise, an accepted pixel SHALL merge into its lane.
REQ-027 Merge rule: data and strobe bytes with strobe_in set SHALL overwrite; other bytes SHALL keep prior values (last write wins).
REQ-028 An accepted pixel with chunk equal to cur_chunk during a full- or flush-triggered emit SHALL start a new accumulator with the same chunk address; it SHALL NOT merge into the emitted chunk.
REQ-029 A decreasing address or an address wrap SHALL be treated only as a chunk change; there is no ordering assumption.
REQ-030 flush_in SHALL set flush_pending.
REQ-031 flush_pending SHALL clear on the emit it causes, or in the same cycle if acc_occ is 0; a flush with an empty accumulator SHALL produce no output.
REQ-032 A flush arriving with an accepted pixel SHALL emit the prior accumulator first, then keep flush_pending set so the new pixel is emitted when out_free allows.
REQ-033 Latency: a pixel completing a chunk at edge t SHALL give valid_out=1 at edge t+1 when out_free, otherwise on the first edge after out_free.
REQ-034 A single pixel per chunk SHALL give sustained throughput of one chunk per cycle when ready_in is constantly high.
REQ-035 valid_out SHALL clear on valid_out && ready_in unless a new emit occurs in that cycle.
REQ-036 data_out, addr_out and strobe_out SHALL be stable while valid_out && !ready_in.
REQ-037 chunks_out SHALL increment on each emit.
REQ-038 partials_out SHALL increment on each emit whose mask is not all ones; both counters SHALL wrap at 2^16.

Reset
REQ-039 While rst_n_in=0: valid_out=0, data_out=0, strobe_out=0, addr_out=0, acc_occ=0, mask=0, flush_pending=0, counters=0, ready_out=0, idle_out=1.
REQ-040 Reset asserted mid-chunk SHALL discard the accumulator and any undelivered output without emitting.
REQ-041 The first accept after deassertion SHALL be possible on the first rising edge with rst_n_in=1.

Structure
REQ-042 Package fb_pkg SHALL hold the default LANES/PIX_W constants and the chunk_t typedef (addr, data, strobe).
REQ-043 One sub-module, fb_out_reg, SHALL implement the 1-entry valid/ready output register.
REQ-044 The accumulator and emit logic SHALL stay in pixel_packer.

Verification
REQ-045 Addrs 0..7 with data 0x1000+i, strobe 2'b11, ready_in=1 -> one chunk: addr_out=0, strobe_out=16'hFFFF, lane i=0x1000+i, partials_out=0.
REQ-046 Addrs 8,9 then 24 -> chunk 1 with strobe_out=16'h000F and partials_out=1, then chunk 3 held until flush_in -> strobe_out=16'h0003.
REQ-047 Addr 5 twice with data 0xAAAA (strobe 11) then 0x55BB (strobe 01) -> lane 5 = 0xAABB, strobe bits [11:10]=11.
REQ-048 ready_in=0 for 10 cycles while streaming 24 pixels -> ready_out falls; no data lost; three chunks in order 0,1,2 with data_out stable while stalled.
REQ-049 Addr 7 written (full chunk emitting) simultaneous with addr 3 of the same chunk -> two chunks with addr_out 0: first full, second strobe_out=16'h00C0.
REQ-050 rst_n_in pulsed low mid-chunk after 4 pixels -> no output, idle_out=1, counters=0; the next chunk is emitted cleanly.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared defaults and types for the pixel packer.
//   DEF_PIX_W / DEF_LANES / DEF_ADDR_W : default geometry of the packer.
//   chunk_t : one output chunk at the default geometry
//             (chunk address, lane-ordered data, lane-aligned byte strobes).
package fb_pkg;

    localparam int DEF_PIX_W   = 16;
    localparam int DEF_LANES   = 8;
    localparam int DEF_ADDR_W  = 20;
    localparam int DEF_BYTES   = DEF_PIX_W / 8;
    localparam int DEF_CHUNK_W = DEF_ADDR_W - $clog2(DEF_LANES);

    typedef struct packed {
        logic [DEF_CHUNK_W-1:0]           addr;
        logic [DEF_LANES*DEF_PIX_W-1:0]   data;
        logic [DEF_LANES*DEF_BYTES-1:0]   strobe;
    } chunk_t;

endpackage

// File: rtl/fb_out_reg.sv
// fb_out_reg: single-entry valid/ready output register.
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : capture load_data; caller only asserts it when the slot is free
//   load_data   : chunk to present downstream
//   ready       : downstream accept
//   valid, data : registered output handshake and payload
// The payload only changes on load, so it is stable while valid && !ready.
module fb_out_reg
    import fb_pkg::*;
#(
    parameter type T = chunk_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  T     load_data,
    input  logic ready,
    output logic valid,
    output T     data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: gathers per-pixel writes into LANES-wide chunks.
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   valid_in / ready_out    : pixel input handshake
//   addr_in, data_in,
//   strobe_in               : pixel address (low bits = lane), data, byte enables
//   flush_in                : one-cycle request to emit a partial chunk
//   valid_out / ready_in    : chunk output handshake
//   addr_out, data_out,
//   strobe_out              : chunk address, lane data, lane-aligned byte enables
//   idle_out                : nothing buffered, nothing pending, no output held
//   chunks_out, partials_out: wrapping counts of emitted / partially-filled chunks
module pixel_packer
    import fb_pkg::*;
#(
    parameter  int PIX_W   = DEF_PIX_W,
    parameter  int LANES   = DEF_LANES,
    parameter  int ADDR_W  = DEF_ADDR_W,
    localparam int BYTES   = PIX_W / 8,
    localparam int LANE_W  = $clog2(LANES),
    localparam int CHUNK_W = ADDR_W - LANE_W
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     valid_in,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic [PIX_W-1:0]         data_in,
    input  logic [BYTES-1:0]         strobe_in,
    input  logic                     flush_in,
    output logic                     ready_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [CHUNK_W-1:0]       addr_out,
    output logic [LANES*PIX_W-1:0]   data_out,
    output logic [LANES*BYTES-1:0]   strobe_out,
    output logic                     idle_out,
    output logic [15:0]              chunks_out,
    output logic [15:0]              partials_out
);

    localparam int LIDX_W = (LANE_W > 0) ? LANE_W : 1;

    typedef struct packed {
        logic [CHUNK_W-1:0]     addr;
        logic [LANES*PIX_W-1:0] data;
        logic [LANES*BYTES-1:0] strobe;
    } out_t;

    // Accumulator state
    logic [CHUNK_W-1:0] cur_chunk_reg;
    logic [LANES-1:0]   mask_reg;
    logic               acc_occ_reg;
    logic               flush_pending_reg;
    logic               flush_pending_next;
    logic [15:0]        chunks_reg;
    logic [15:0]        partials_reg;

    logic [LIDX_W-1:0]  lane;
    logic [CHUNK_W-1:0] chunk_in;
    logic [LANES-1:0]   lane_hit;
    logic               out_free;
    logic               accept;
    logic               mask_full;
    logic               flush_req;
    logic               emit;
    logic               start_new;

    logic [LANES*PIX_W-1:0] emit_data;
    logic [LANES*BYTES-1:0] emit_strobe;
    out_t                   emit_word;
    out_t                   out_word;

    generate
        if (LANE_W > 0) begin : g_lane
            assign lane = addr_in[LANE_W-1:0];
        end else begin : g_no_lane
            assign lane = '0;
        end
    endgenerate

    assign chunk_in  = addr_in[ADDR_W-1:LANE_W];
    assign out_free  = !valid_out || ready_in;
    // Gated by reset so nothing is taken while the design is held in reset.
    assign ready_out = rst_n_in && (!acc_occ_reg || out_free);
    assign accept    = valid_in && ready_out;
    assign lane_hit  = accept ? (LANES'(1) << lane) : '0;
    assign mask_full = &mask_reg;
    // A flush arriving this cycle acts immediately, not one cycle late.
    assign flush_req = flush_pending_reg || flush_in;
    assign emit      = acc_occ_reg && out_free &&
                       (mask_full || flush_req || (accept && (chunk_in != cur_chunk_reg)));
    // A pixel never merges into a chunk that is leaving this cycle.
    assign start_new = accept && (!acc_occ_reg || emit);

    // A flush that arrives with a pixel empties the old chunk now and stays
    // pending so the new pixel goes out as soon as the output slot frees up.
    always_comb begin
        flush_pending_next = flush_req && acc_occ_reg && !emit;
        if (accept && flush_in) begin
            flush_pending_next = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
            logic [PIX_W-1:0] data_reg;
            logic [BYTES-1:0] strb_reg;
            logic [PIX_W-1:0] merged_data;
            logic [BYTES-1:0] merged_strb;
            logic             keep;

            // Prior bytes survive only within a live lane of the same chunk;
            // a freshly opened lane starts from zero.
            assign keep = !start_new && mask_reg[gi];

            always_comb begin
                merged_data = keep ? data_reg : '0;
                merged_strb = keep ? strb_reg : '0;
                for (int b = 0; b < BYTES; b++) begin
                    if (strobe_in[b]) begin
                        merged_data[b*8 +: 8] = data_in[b*8 +: 8];
                        merged_strb[b]        = 1'b1;
                    end
                end
            end

            // Lane payload needs no reset: the mask qualifies every use of it.
            always_ff @(posedge clk_in) begin
                if (lane_hit[gi]) begin
                    data_reg <= merged_data;
                    strb_reg <= merged_strb;
                end
            end

            assign emit_data[gi*PIX_W +: PIX_W]   = mask_reg[gi] ? data_reg : '0;
            assign emit_strobe[gi*BYTES +: BYTES] = mask_reg[gi] ? strb_reg : '0;
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cur_chunk_reg     <= '0;
            mask_reg          <= '0;
            acc_occ_reg       <= 1'b0;
            flush_pending_reg <= 1'b0;
            chunks_reg        <= '0;
            partials_reg      <= '0;
        end else begin
            if (start_new) begin
                cur_chunk_reg <= chunk_in;
                mask_reg      <= lane_hit;
                acc_occ_reg   <= 1'b1;
            end else if (accept) begin
                mask_reg      <= mask_reg | lane_hit;
            end else if (emit) begin
                mask_reg      <= '0;
                acc_occ_reg   <= 1'b0;
            end
            flush_pending_reg <= flush_pending_next;
            if (emit) begin
                chunks_reg <= chunks_reg + 16'd1;
                if (!mask_full) begin
                    partials_reg <= partials_reg + 16'd1;
                end
            end
        end
    end

    assign emit_word.addr   = cur_chunk_reg;
    assign emit_word.data   = emit_data;
    assign emit_word.strobe = emit_strobe;

    fb_out_reg #(
        .T (out_t)
    ) u_out_reg (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .load      (emit),
        .load_data (emit_word),
        .ready     (ready_in),
        .valid     (valid_out),
        .data      (out_word)
    );

    assign addr_out     = out_word.addr;
    assign data_out     = out_word.data;
    assign strobe_out   = out_word.strobe;
    assign idle_out     = !acc_occ_reg && !flush_pending_reg && !valid_out;
    assign chunks_out   = chunks_reg;
    assign partials_out = partials_reg;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          valid_in;
    logic [19:0]   addr_in;
    logic [15:0]   data_in;
    logic [1:0]    strobe_in;
    logic          flush_in;
    logic          ready_out;
    logic          valid_out;
    logic          ready_in;
    logic [16:0]   addr_out;
    logic [127:0]  data_out;
    logic [15:0]   strobe_out;
    logic          idle_out;
    logic [15:0]   chunks_out;
    logic [15:0]   partials_out;

    typedef struct {
        logic [16:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic seen_ready_low = 1'b0;

    pixel_packer dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .strobe_in    (strobe_in),
        .flush_in     (flush_in),
        .ready_out    (ready_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .strobe_out   (strobe_out),
        .idle_out     (idle_out),
        .chunks_out   (chunks_out),
        .partials_out (partials_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, between active edges.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in) begin
            if (!ready_out) seen_ready_low = 1'b1;
            if (valid_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_output observed addr=%0h expected=none", addr_out);
                end else if (ready_in) begin
                    e = sb.pop_front();
                    chk("out_addr", 128'(addr_out), 128'(e.addr));
                    chk("out_data", data_out, e.data);
                    chk("out_strobe", 128'(strobe_out), 128'(e.strb));
                    $display("chunk addr=%0h strobe=%0h data=%0h", addr_out, strobe_out, data_out);
                end else begin
                    chk("stall_data", data_out, sb[0].data);
                    chk("stall_addr", 128'(addr_out), 128'(sb[0].addr));
                end
            end
        end
    end

    task automatic push(input logic [16:0] a, input logic [127:0] d, input logic [15:0] s);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel was taken.
    task automatic send_pix(input logic [19:0] a, input logic [15:0] d, input logic [1:0] s);
        valid_in  = 1'b1;
        addr_in   = a;
        data_in   = d;
        strobe_in = s;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (ready_out) begin
                @(posedge clk_in);
                #1;
                valid_in = 1'b0;
                return;
            end
            @(posedge clk_in);
            #1;
        end
        checks++;
        errors++;
        $error("FAIL send_timeout observed=ready_low expected=accept addr=%0h", a);
        valid_in = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && !valid_out) return;
            @(posedge clk_in);
            #1;
        end
        checks++;
        errors++;
        $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;

        rst_n_in  = 1'b0;
        valid_in  = 1'b0;
        addr_in   = '0;
        data_in   = '0;
        strobe_in = '0;
        flush_in  = 1'b0;
        ready_in  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", 128'(valid_out), 128'(0));
        chk("rst_data", data_out, 128'(0));
        chk("rst_strobe", 128'(strobe_out), 128'(0));
        chk("rst_addr", 128'(addr_out), 128'(0));
        chk("rst_ready", 128'(ready_out), 128'(0));
        chk("rst_idle", 128'(idle_out), 128'(1));
        chk("rst_chunks", 128'(chunks_out), 128'(0));
        chk("rst_partials", 128'(partials_out), 128'(0));
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // One full chunk
        d = '0;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(16'h1000 + i);
        push(17'd0, d, 16'hFFFF);
        for (int i = 0; i < 8; i++) send_pix(20'(i), 16'(16'h1000 + i), 2'b11);
        wait_drain();
        chk("t1_chunks", 128'(chunks_out), 128'(1));
        chk("t1_partials", 128'(partials_out), 128'(0));

        // Chunk change emits a partial; the next chunk waits for a flush
        push(17'd1, 128'hB009_B008, 16'h000F);
        send_pix(20'd8, 16'hB008, 2'b11);
        send_pix(20'd9, 16'hB009, 2'b11);
        send_pix(20'd24, 16'hB018, 2'b11);
        repeat (10) @(posedge clk_in);
        #1;
        chk("t2_held_idle", 128'(idle_out), 128'(0));
        chk("t2_chunks", 128'(chunks_out), 128'(2));
        chk("t2_partials", 128'(partials_out), 128'(1));
        push(17'd3, 128'hB018, 16'h0003);
        pulse_flush();
        wait_drain();
        chk("t2_idle", 128'(idle_out), 128'(1));
        chk("t2_partials_f", 128'(partials_out), 128'(2));

        // Byte-strobe merge within one lane
        d = '0;
        d[80 +: 16] = 16'hAABB;
        push(17'd0, d, 16'h0C00);
        send_pix(20'd5, 16'hAAAA, 2'b11);
        send_pix(20'd5, 16'h55BB, 2'b01);
        pulse_flush();
        wait_drain();
        chk("t3_chunks", 128'(chunks_out), 128'(4));
        chk("t3_partials", 128'(partials_out), 128'(3));

        // Streaming with a 10-cycle downstream stall
        seen_ready_low = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = '0;
            for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(16'h2000 + k*8 + i);
            push(17'(k), d, 16'hFFFF);
        end
        fork
            for (int i = 0; i < 24; i++) send_pix(20'(i), 16'(16'h2000 + i), 2'b11);
            begin
                repeat (5) @(posedge clk_in);
                #1;
                ready_in = 1'b0;
                repeat (10) @(posedge clk_in);
                #1;
                ready_in = 1'b1;
            end
        join
        wait_drain();
        chk("t4_ready_fell", 128'(seen_ready_low), 128'(1));
        chk("t4_chunks", 128'(chunks_out), 128'(7));
        chk("t4_partials", 128'(partials_out), 128'(3));

        // Same-chunk pixel arriving while the full chunk is emitted
        d = '0;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(16'h4000 + i);
        push(17'd0, d, 16'hFFFF);
        d = '0;
        d[48 +: 16] = 16'h3333;
        push(17'd0, d, 16'h00C0);
        for (int i = 0; i < 8; i++) send_pix(20'(i), 16'(16'h4000 + i), 2'b11);
        send_pix(20'd3, 16'h3333, 2'b11);
        pulse_flush();
        wait_drain();
        chk("t5_chunks", 128'(chunks_out), 128'(9));
        chk("t5_partials", 128'(partials_out), 128'(4));

        // Reset mid-chunk discards everything
        for (int i = 16; i < 20; i++) send_pix(20'(i), 16'(16'h7000 + i), 2'b11);
        rst_n_in = 1'b0;
        valid_in = 1'b1;
        addr_in  = 20'd32;
        data_in  = 16'h5000;
        strobe_in = 2'b11;
        @(negedge clk_in);
        chk("t6_rst_idle", 128'(idle_out), 128'(1));
        chk("t6_rst_chunks", 128'(chunks_out), 128'(0));
        chk("t6_rst_partials", 128'(partials_out), 128'(0));
        chk("t6_rst_valid", 128'(valid_out), 128'(0));
        chk("t6_rst_ready", 128'(ready_out), 128'(0));
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("t6_first_ready", 128'(ready_out), 128'(1));
        d = '0;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(16'h5000 + i);
        push(17'd4, d, 16'hFFFF);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        for (int i = 1; i < 8; i++) send_pix(20'(32 + i), 16'(16'h5000 + i), 2'b11);
        wait_drain();
        chk("t6_chunks", 128'(chunks_out), 128'(1));
        chk("t6_partials", 128'(partials_out), 128'(0));
        chk("t6_idle", 128'(idle_out), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
